// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// change_pkg : coin denominations, payout FSM states, greedy coin selection
// Revision   : 1.0
// ============================================================================
package change_pkg;

    localparam logic [1:0] DEN_1  = 2'd0;
    localparam logic [1:0] DEN_5  = 2'd1;
    localparam logic [1:0] DEN_10 = 2'd2;
    localparam logic [1:0] DEN_50 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PROD = 2'd2,
        ST_COIN = 2'd3
    } state_t;

    function automatic logic [5:0] den_value(input logic [1:0] den);
        case (den)
            DEN_1:   return 6'd1;
            DEN_5:   return 6'd5;
            DEN_10:  return 6'd10;
            default: return 6'd50;
        endcase
    endfunction

    // Largest coin not exceeding amt, so the payout subtraction cannot wrap.
    function automatic logic [1:0] den_select(input logic [31:0] amt);
        if (amt >= 32'd50)
            return DEN_50;
        else if (amt >= 32'd10)
            return DEN_10;
        else if (amt >= 32'd5)
            return DEN_5;
        else
            return DEN_1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_event_fifo.sv
`default_nettype none
// ============================================================================
// event_fifo : synchronous FIFO holding {product, change} payout events
// Revision   : 1.0
// ============================================================================
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// change_dispenser : queues vending events and pays out product then coins
// Revision         : 1.0
// ============================================================================
module change_dispenser
    import change_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] MO,
    input  logic [1:0]   PO,
    output logic         prod_valid,
    output logic [1:0]   prod_code,
    input  logic         prod_ready,
    output logic         coin_valid,
    output logic [1:0]   coin_den,
    input  logic         coin_ready,
    output logic         busy,
    output logic         overflow
);

    state_t       state;
    logic [W-1:0] amt;
    logic [1:0]   code;
    logic         evt;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [W+1:0] fifo_dout;
    logic [W-1:0] head_amt;
    logic [1:0]   head_code;
    logic [W-1:0] amt_after;

    assign evt       = (MO != '0) || (PO != 2'd0);
    assign fifo_pop  = (state == ST_LOAD);
    assign head_amt  = fifo_dout[W-1:0];
    assign head_code = fifo_dout[W+1:W];
    assign amt_after = amt - W'(den_value(coin_den));
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign prod_code = code;

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W + 2)
    ) u_event_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt),
        .pop   (fifo_pop),
        .din   ({PO, MO}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            overflow <= 1'b0;
        else if (evt && fifo_full && !fifo_pop)
            overflow <= 1'b1;
    end

    // Leaving IDLE on an incoming event lets LOAD find it in the FIFO one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            amt        <= '0;
            code       <= 2'd0;
            prod_valid <= 1'b0;
            coin_valid <= 1'b0;
            coin_den   <= DEN_1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty || evt)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    amt  <= head_amt;
                    code <= head_code;
                    if (head_code != 2'd0) begin
                        state      <= ST_PROD;
                        prod_valid <= 1'b1;
                    end else if (head_amt != '0) begin
                        state      <= ST_COIN;
                        coin_valid <= 1'b1;
                        coin_den   <= den_select(32'(head_amt));
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PROD: begin
                    if (prod_ready) begin
                        prod_valid <= 1'b0;
                        if (amt != '0) begin
                            state      <= ST_COIN;
                            coin_valid <= 1'b1;
                            coin_den   <= den_select(32'(amt));
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_COIN: begin
                    if (coin_ready) begin
                        amt <= amt_after;
                        if (amt_after == '0) begin
                            state      <= ST_IDLE;
                            coin_valid <= 1'b0;
                            coin_den   <= DEN_1;
                        end else begin
                            coin_den <= den_select(32'(amt_after));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Back-end payout unit that sits on the output side of the vending controller. Every cycle it samples the controller's change amount and product code, and queues each non-zero (change, product) event in a small FIFO. It then pays each event out in order: first the product, through a ready/valid product port, then the change as a greedy sequence of coins, one coin per handshake.

## Interface
Parameters:
- DEPTH, 4, number of event FIFO entries (power of two, ≥2)
- W, 8, width of the change amount

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low
- MO  in  W  change amount from the vending controller; sampled every cycle
- PO  in  2  product code from the vending controller (0 = none, 1..3 = product)
- prod_valid  out  1  product dispense request
- prod_code  out  2  product being dispensed; valid only when prod_valid=1
- prod_ready  in  1  product mechanism accepts the request
- coin_valid  out  1  coin dispense request
- coin_den  out  2  coin denomination code: 0=1, 1=5, 2=10, 3=50
- coin_ready  in  1  coin mechanism accepts the coin
- busy  out  1  FIFO non-empty or FSM not in IDLE
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full

## Operation
- Event detection: each cycle with MO≠0 or PO≠0 is one event. Consecutive non-zero cycles are distinct events; there is no merging.
- FIFO: push {PO, MO} on an event.
  - Full FIFO with no pop in the same cycle: the event is dropped and overflow is set. overflow clears only on reset.
  - Full FIFO with a pop in the same cycle: the push succeeds.
- FSM states: IDLE, LOAD, PROD, COIN.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD: pop the head into working registers amt (W bits) and code (2 bits). Go to PROD if code≠0, otherwise to COIN.
  - PROD: prod_valid=1, prod_code=code. On prod_ready, go to COIN if amt≠0, otherwise to IDLE.
  - COIN: coin_valid=1; coin_den is the largest denomination ≤ amt (50, 10, 5, 1). On coin_ready, amt ← amt − value(coin_den). If the new amt=0, go to IDLE.
- prod_code and coin_den are stable while their valid signal is high and ready is low. valid never drops before its ready.
- Subtraction never underflows, because a denomination is only chosen when it is ≤ amt. An amt of 255 pays out as 5×50, 1×5.
- Reset mid-operation: an active rst on any edge empties the FIFO, forces IDLE and drops any pending payout.
- Reset values: prod_valid=0, prod_code=0, coin_valid=0, coin_den=0, busy=0, overflow=0. FIFO pointers, count, amt and code are all 0.

## Timing
- Event present in cycle t → pushed at the edge ending t → LOAD in cycle t+1 (from IDLE) → prod_valid or coin_valid first asserted in cycle t+2.
- Products are handed off at most one per cycle and coins at most one per cycle (each coin has a one-cycle handshake).
- IDLE → LOAD costs one cycle between events. Back-to-back events are therefore separated by at least two cycles plus their handshake cycles.
- All outputs are registered or decoded only from registered state. There is no combinational path from MO/PO to any output.
- busy rises in cycle t+1 after a push and falls in the cycle after the final handshake of the last event.

## Structure
- Shared package change_pkg:
  - denomination codes and their values (1, 5, 10, 50)
  - FSM state enum (IDLE, LOAD, PROD, COIN)
  - function den_select(amt) returning the greedy code
- Sub-module event_fifo: synchronous FIFO with parameters DEPTH and width W+2. Ports: push, pop, din, dout, full, empty. A push while full is allowed when pop is asserted in the same cycle.
- Top level contains event detection, the FSM, the amt/code registers and the overflow flag.

## Test plan
- Reset behaviour: hold rst=0 for 2 cycles while MO=20 → all outputs 0, busy=0, nothing queued.
- Single purchase: PO=2, MO=87 for one cycle, ready tied high →
  - prod_valid with prod_code=2 at t+2;
  - then coin_den sequence 3,2,2,2,1,0,0 (50,10,10,10,5,1,1);
  - then busy=0.
- Backpressure: PO=1, MO=15, coin_ready low for 3 cycles during COIN → coin_den held at 2 with valid high; then codes 2,1 as ready rises.
- Refund only: PO=0, MO=6 → no prod_valid; coins 1,0 (5,1).
- Overflow: 6 consecutive event cycles (PO=3, MO=0) with prod_ready=0 → overflow=1 after the 6th event. Releasing ready yields exactly 5 products: one popped into LOAD while events were arriving plus 4 held in the FIFO.
- Reset mid-payout: rst=0 during the COIN state of the MO=87 case → the next cycle shows coin_valid=0, busy=0, and no further coins.
